// File: rtl/note_scheduler_if.sv
// Control and status bundle between the top-level controls / notes ROM and
// the note scheduler. The master side drives playback controls and the ROM
// duration code; the slave side is the scheduler itself.
interface note_scheduler_if #(
    parameter int IDX_BW  = 6,
    parameter int TICK_BW = 24,
    parameter int DUR_BW  = 4
);
    logic               start_i;
    logic               stop_i;
    logic               pause_i;
    logic               loop_i;
    logic               legato_i;
    logic [TICK_BW-1:0] tick_max_i;
    logic [IDX_BW-1:0]  seq_last_i;
    logic [DUR_BW-1:0]  dur_i;
    logic [IDX_BW-1:0]  note_index_o;
    logic               note_on_o;
    logic               gate_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output start_i, stop_i, pause_i, loop_i, legato_i,
        output tick_max_i, seq_last_i, dur_i,
        input  note_index_o, note_on_o, gate_o, busy_o, done_o
    );

    modport slave (
        input  start_i, stop_i, pause_i, loop_i, legato_i,
        input  tick_max_i, seq_last_i, dur_i,
        output note_index_o, note_on_o, gate_o, busy_o, done_o
    );
endinterface

// File: rtl/note_scheduler.sv
// Playback controller for the tone datapath: steps the note index through
// the notes ROM with start/stop/pause/loop control, pulses note-on for the
// envelope generator and gates the PWM output (staccato rest or legato).
module note_scheduler #(
    parameter int IDX_BW  = 6,
    parameter int TICK_BW = 24,
    parameter int DUR_BW  = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    note_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP, PAUSE} state_t;

    state_t             state;
    state_t             state_n;
    state_t             run_state;
    logic               ret_play;
    logic               ret_play_n;
    logic [TICK_BW-1:0] pres;
    logic [TICK_BW-1:0] pres_n;
    logic [TICK_BW-1:0] tick_last;
    logic               tick;
    logic [DUR_BW-1:0]  dur_cnt;
    logic [DUR_BW-1:0]  dur_cnt_n;
    logic [DUR_BW-1:0]  dur_q;
    logic [DUR_BW-1:0]  dur_eff;
    logic [IDX_BW-1:0]  idx;
    logic [IDX_BW-1:0]  idx_n;
    logic               advance;
    logic               note_on_q;
    logic               note_on_n;
    logic               done_q;
    logic               done_n;
    logic               gate_q;
    logic               busy_q;

    // A tick_max of 0 behaves as 1, so the last prescaler count is 0 then.
    // ">=" keeps the prescaler from running away if tick_max drops live.
    assign tick_last = (bus.tick_max_i == '0) ? '0 : bus.tick_max_i - TICK_BW'(1);
    assign tick      = (pres >= tick_last);

    // The ROM output only reflects the new index during the note-on cycle,
    // so duration is taken live then and from the held copy afterwards.
    assign dur_eff = note_on_q ? bus.dur_i : dur_q;

    // While paused, resuming performs the step of the saved state.
    assign run_state = (state == PAUSE) ? (ret_play ? PLAY : GAP) : state;

    // Next-state logic: stop > start > pause > normal counting/advance.
    always_comb begin
        state_n    = state;
        ret_play_n = ret_play;
        pres_n     = pres;
        dur_cnt_n  = dur_cnt;
        idx_n      = idx;
        note_on_n  = 1'b0;
        done_n     = 1'b0;
        advance    = 1'b0;

        if (state != IDLE && bus.stop_i) begin
            state_n    = IDLE;
            idx_n      = '0;
            pres_n     = '0;
            dur_cnt_n  = '0;
            ret_play_n = 1'b0;
        end else if (state == IDLE) begin
            if (bus.start_i && !bus.stop_i) begin
                state_n   = PLAY;
                idx_n     = '0;
                pres_n    = '0;
                dur_cnt_n = '0;
                note_on_n = 1'b1;
            end
        end else if (bus.pause_i) begin
            if (state != PAUSE) begin
                state_n    = PAUSE;
                ret_play_n = (state == PLAY);
            end
        end else begin
            state_n = run_state;
            pres_n  = tick ? '0 : pres + TICK_BW'(1);
            if (run_state == PLAY && tick) begin
                if (dur_cnt == dur_eff) begin
                    if (bus.legato_i) begin
                        advance = 1'b1;
                    end else begin
                        state_n   = GAP;
                        pres_n    = '0;
                        dur_cnt_n = '0;
                    end
                end else begin
                    dur_cnt_n = dur_cnt + DUR_BW'(1);
                end
            end
            if (run_state == GAP && tick) begin
                advance = 1'b1;
            end
            if (advance) begin
                pres_n    = '0;
                dur_cnt_n = '0;
                if (idx != bus.seq_last_i) begin
                    idx_n     = idx + IDX_BW'(1);
                    state_n   = PLAY;
                    note_on_n = 1'b1;
                end else if (bus.loop_i) begin
                    idx_n     = '0;
                    state_n   = PLAY;
                    note_on_n = 1'b1;
                end else begin
                    idx_n   = '0;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            ret_play  <= 1'b0;
            pres      <= '0;
            dur_cnt   <= '0;
            idx       <= '0;
            note_on_q <= 1'b0;
            done_q    <= 1'b0;
            gate_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            ret_play  <= ret_play_n;
            pres      <= pres_n;
            dur_cnt   <= dur_cnt_n;
            idx       <= idx_n;
            note_on_q <= note_on_n;
            done_q    <= done_n;
            gate_q    <= (state_n == PLAY);
            busy_q    <= (state_n != IDLE);
        end
    end

    // Capture the note's duration code during its note-on cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dur_q <= '0;
        end else if (note_on_q) begin
            dur_q <= bus.dur_i;
        end
    end

    assign bus.note_index_o = idx;
    assign bus.note_on_o    = note_on_q;
    assign bus.gate_o       = gate_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: note timing, legato, loop, pause,
// stop/restart, asynchronous reset and the tick_max=0 case.
module tb_note_scheduler;

    localparam int IDX_BW  = 6;
    localparam int TICK_BW = 24;
    localparam int DUR_BW  = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    note_scheduler_if #(.IDX_BW(IDX_BW), .TICK_BW(TICK_BW), .DUR_BW(DUR_BW)) bus ();

    note_scheduler #(.IDX_BW(IDX_BW), .TICK_BW(TICK_BW), .DUR_BW(DUR_BW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int c, input logic [31:0] idx,
                            input logic non, input logic gate, input logic busy, input logic done);
        checkOutput($sformatf("%s_idx_c%0d", tag, c), 32'(bus.note_index_o), idx);
        checkOutput($sformatf("%s_noteon_c%0d", tag, c), 32'(bus.note_on_o), 32'(non));
        checkOutput($sformatf("%s_gate_c%0d", tag, c), 32'(bus.gate_o), 32'(gate));
        checkOutput($sformatf("%s_busy_c%0d", tag, c), 32'(bus.busy_o), 32'(busy));
        checkOutput($sformatf("%s_done_c%0d", tag, c), 32'(bus.done_o), 32'(done));
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        total = 0;
        bad   = 0;
        bus.start_i    = 1'b0;
        bus.stop_i     = 1'b0;
        bus.pause_i    = 1'b0;
        bus.loop_i     = 1'b0;
        bus.legato_i   = 1'b0;
        bus.tick_max_i = 24'd4;
        bus.seq_last_i = 6'd1;
        bus.dur_i      = 4'd1;

        // Reset state
        applyStimulus();
        applyStimulus();
        checkAll("rst", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus();

        // Basic note timing: T=4, dur=1, staccato, two notes
        bus.start_i = 1'b1;
        applyStimulus();
        bus.start_i = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            checkAll("basic", c, (c >= 13 && c <= 24) ? 1 : 0,
                     (c == 1 || c == 13), (c <= 8 || (c >= 13 && c <= 20)),
                     (c <= 24), (c == 25));
            applyStimulus();
        end

        // Legato: same notes without the rest
        bus.legato_i = 1'b1;
        bus.start_i  = 1'b1;
        applyStimulus();
        bus.start_i  = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            checkAll("legato", c, (c >= 9 && c <= 16) ? 1 : 0,
                     (c == 1 || c == 9), (c <= 16), (c <= 16), (c == 17));
            applyStimulus();
        end

        // Loop: seq_last=2, T=2, dur=0, staccato; 4-cycle note period
        bus.legato_i   = 1'b0;
        bus.loop_i     = 1'b1;
        bus.seq_last_i = 6'd2;
        bus.tick_max_i = 24'd2;
        bus.dur_i      = 4'd0;
        bus.start_i    = 1'b1;
        applyStimulus();
        bus.start_i    = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            checkAll("loop", c, ((c - 1) / 4) % 3, ((c - 1) % 4 == 0),
                     ((c - 1) % 4 < 2), 1'b1, 1'b0);
            applyStimulus();
        end
        bus.stop_i = 1'b1;
        applyStimulus();
        bus.stop_i = 1'b0;
        checkAll("loopstop", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Pause for 10 cycles during the note: note end moves from 8 to 18
        bus.loop_i     = 1'b0;
        bus.seq_last_i = 6'd0;
        bus.tick_max_i = 24'd4;
        bus.dur_i      = 4'd1;
        bus.start_i    = 1'b1;
        applyStimulus();
        bus.start_i    = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            checkAll("pause", c, 0, (c == 1), (c <= 3 || (c >= 14 && c <= 18)),
                     (c <= 22), (c == 23));
            bus.pause_i = (c >= 3 && c <= 12);
            applyStimulus();
        end
        bus.pause_i = 1'b0;

        // Stop with start high during the second note, then restart
        bus.seq_last_i = 6'd3;
        bus.tick_max_i = 24'd2;
        bus.dur_i      = 4'd0;
        bus.start_i    = 1'b1;
        applyStimulus();
        bus.start_i    = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checkAll("pre", c, (c == 5) ? 1 : 0, (c == 1 || c == 5),
                     (c <= 2 || c == 5), 1'b1, 1'b0);
            if (c < 5) applyStimulus();
        end
        bus.stop_i  = 1'b1;
        bus.start_i = 1'b1;
        applyStimulus();
        checkAll("stop", 6, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.stop_i = 1'b0;
        applyStimulus();
        checkAll("restart", 7, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.start_i = 1'b0;
        for (int c = 8; c <= 13; c++) begin
            applyStimulus();
            checkAll("run", c, (c >= 11) ? 1 : 0, (c == 11),
                     (c == 8 || c == 11 || c == 12), 1'b1, 1'b0);
        end

        // Asynchronous reset mid-GAP (cycle 13 is GAP of note index 1)
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("arst", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // tick_max=0 behaves as 1: each dur-0 legato note lasts one cycle
        bus.tick_max_i = 24'd0;
        bus.legato_i   = 1'b1;
        bus.seq_last_i = 6'd2;
        bus.dur_i      = 4'd0;
        #3;
        rst_n = 1'b1;
        applyStimulus();
        bus.start_i = 1'b1;
        applyStimulus();
        bus.start_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checkAll("t0", c, (c <= 3) ? c - 1 : 0, (c <= 3), (c <= 3),
                     (c <= 3), (c == 4));
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Playback controller for the tone datapath. It replaces free-running note stepping with start, stop, pause and loop control.
- It sequences the note index into the notes ROM and pulses note-on into the envelope generator.
- It gates the PWM output so notes can be separated by a rest (staccato) or run together (legato).
- It sits between the top-level control inputs (ui_in) and the NotesRom, EnvelopeGenerator and PwmModulator instances.

Parameters:
- IDX_BW, 6, width of the note index and the last-index input.
- TICK_BW, 24, width of the tick prescaler and of tick_max_i.
- DUR_BW, 4, width of the per-note duration code.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  start playback from index 0 (level, acted on while IDLE).
- stop_i  input  1  abort playback (level).
- pause_i  input  1  freeze playback while high.
- loop_i  input  1  wrap to index 0 after the last note instead of finishing.
- legato_i  input  1  0: one rest tick after every note; 1: no rest.
- tick_max_i  input  TICK_BW  tick period in clk cycles; 0 is treated as 1.
- seq_last_i  input  IDX_BW  index of the last note in the sequence.
- dur_i  input  DUR_BW  duration code of the current note (combinational from the ROM at note_index_o). Note length is dur_i+1 ticks.
- note_index_o  output  IDX_BW  current note index.
- note_on_o  output  1  one-cycle pulse at the start of each note.
- gate_o  output  1  high while a note sounds; gates the PWM output.
- busy_o  output  1  high in any state except IDLE.
- done_o  output  1  one-cycle pulse when a non-looping sequence ends.

Behaviour:
- Reset (async, rst_ni=0):
  - State is IDLE and all counters are 0.
  - note_index_o=0; note_on_o, gate_o, busy_o and done_o are 0.
- All outputs are registered.
- States and their outputs:
  - IDLE: gate 0, busy 0.
  - PLAY: gate 1, busy 1.
  - GAP: gate 0, busy 1.
  - PAUSE: gate 0, busy 1.
- Tick prescaler:
  - Counts 0..T-1, where T = max(tick_max_i,1). A tick is produced when the count reaches T-1, after which it wraps to 0.
  - Runs only in PLAY and GAP.
  - Cleared to 0 on every note start and on entry to GAP.
  - tick_max_i is read live; a change takes effect at the next wrap.
- Duration counter:
  - Counts ticks within PLAY.
  - The note ends on the tick at which the count equals the dur_i value sampled at note start.
  - The sampled dur is held for the whole note.
- Priority when inputs coincide: stop_i > start_i > pause_i.
- IDLE -> PLAY when start_i=1 (and stop_i=0). On that edge:
  - note_index_o <= 0.
  - note_on_o <= 1 for exactly one cycle.
  - gate_o <= 1.
  - Latency from start_i sampled to gate_o/note_on_o high is 1 cycle.
- End of note in PLAY:
  - legato_i=0: go to GAP.
  - legato_i=1: ADVANCE immediately.
- GAP lasts exactly T cycles, then ADVANCE.
- ADVANCE (a transition action, not a state):
  - If note_index_o != seq_last_i: increment the index, go to PLAY, pulse note_on_o.
  - If note_index_o == seq_last_i and loop_i=1: index <= 0, go to PLAY, pulse note_on_o.
  - If note_index_o == seq_last_i and loop_i=0: go to IDLE, pulse done_o for 1 cycle, gate 0, index <= 0.
- With legato_i=1, consecutive notes keep gate_o high continuously. note_on_o still pulses on each new index.
- Pause:
  - pause_i=1 in PLAY or GAP -> PAUSE on the next edge.
  - The prescaler, duration counter, index and a 1-bit return state are frozen.
  - pause_i=0 -> return to the saved state and continue counting where it stopped.
  - No note_on_o pulse on resume.
- Stop:
  - stop_i=1 in any non-IDLE state -> IDLE next edge.
  - Index and counters are cleared to 0; gate 0; no done_o pulse.
- seq_last_i is compared at ADVANCE only. If it drops below the current index, the index keeps counting up and wraps modulo 2^IDX_BW until it matches.
- start_i held high in PLAY, GAP or PAUSE has no effect.
- start_i held high in IDLE right after done_o restarts playback on the following edge.

Test Plan:
- Basic note timing: T=4, dur_i=1, legato 0, seq_last 1, loop 0, 1-cycle start pulse.
  - note_on_o at cycles 1 and 13.
  - gate_o high for cycles 1-8 and 13-20; low for 9-12 and 21+.
  - done_o pulses at cycle 25 with index 0 and busy_o 0.
- Legato: same setup with legato 1.
  - gate_o high continuously for cycles 1-16.
  - note_on_o pulses at cycles 1 and 9.
  - done_o pulses at cycle 17.
- Loop: loop 1, seq_last 2, T=2, dur 0.
  - Index sequence 0,1,2,0,1…, with note_on_o on every change.
  - done_o is never asserted over 40 cycles.
- Pause: pause_i raised for 10 cycles mid-note.
  - gate_o is 0 during the pause.
  - The note ends exactly 10 cycles later than without the pause.
  - No extra note_on_o pulse.
- Stop and restart: stop_i with start_i high in the same cycle during PLAY.
  - IDLE next cycle, no done_o.
  - With start_i still high, PLAY at index 0 on the following cycle.
- Reset and degenerate tick: rst_ni asserted mid-GAP.
  - All outputs 0 immediately (asynchronous).
  - With tick_max_i=0 after release, each dur 0 note lasts exactly 1 cycle.
